// File: rtl/ual_sequencer.sv
// Registered valid/ready front end for the 4-bit combinational UAL: decodes the opcode, holds operands, captures result/flags.
// Optional sticky overflow flag (sticky_clr/sticky_of ports) is built when UAL_STICKY_OF_EN is defined.
module ual_sequencer #(
    parameter bit IDLE_CLEAR = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [2:0] req_op,
    input  logic [3:0] req_a,
    input  logic [3:0] req_b,
    output logic [3:0] ual_in0,
    output logic [3:0] ual_in1,
    output logic [4:0] ual_sel,
    input  logic [7:0] ual_out,
    input  logic [1:0] ual_flags,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic [1:0] rsp_flags,
    output logic       rsp_err
`ifdef UAL_STICKY_OF_EN
    ,
    input  logic       sticky_clr,
    output logic       sticky_of
`endif
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t     state_reg, state_next;
    logic [3:0] in0_reg, in0_next;
    logic [3:0] in1_reg, in1_next;
    logic [4:0] sel_reg, sel_next;
    logic [7:0] data_reg, data_next;
    logic [1:0] flags_reg, flags_next;
    logic       err_reg, err_next;
    logic [4:0] sel_dec;
    logic       op_legal;

    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_dec
            assign sel_dec[gi] = (req_op == 3'(gi));
        end
    endgenerate

    assign op_legal = (req_op <= 3'd4);

    always_comb begin
        state_next = state_reg;
        in0_next   = in0_reg;
        in1_next   = in1_reg;
        sel_next   = sel_reg;
        data_next  = data_reg;
        flags_next = flags_reg;
        err_next   = err_reg;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    if (op_legal) begin
                        in0_next   = req_a;
                        in1_next   = req_b;
                        sel_next   = sel_dec;
                        state_next = EXEC;
                    end else begin
                        // Illegal ops skip the UAL entirely and answer with an error
                        sel_next   = 5'd0;
                        data_next  = 8'd0;
                        flags_next = 2'd0;
                        err_next   = 1'b1;
                        state_next = RESP;
                    end
                end
            end
            EXEC: begin
                data_next  = ual_out;
                flags_next = ual_flags;
                err_next   = 1'b0;
                state_next = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                    if (IDLE_CLEAR) begin
                        in0_next = 4'd0;
                        in1_next = 4'd0;
                        sel_next = 5'd0;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in0_reg   <= 4'd0;
            in1_reg   <= 4'd0;
            sel_reg   <= 5'd0;
            data_reg  <= 8'd0;
            flags_reg <= 2'd0;
            err_reg   <= 1'b0;
        end else begin
            in0_reg   <= in0_next;
            in1_reg   <= in1_next;
            sel_reg   <= sel_next;
            data_reg  <= data_next;
            flags_reg <= flags_next;
            err_reg   <= err_next;
        end
    end

`ifdef UAL_STICKY_OF_EN
    // Overflow position inside ual_flags (ZF is bit 0, OF is bit 1)
    localparam int OF_BIT = 1;

    logic sticky_reg, sticky_next;

    always_comb begin
        sticky_next = sticky_reg;
        if (sticky_clr) begin
            sticky_next = 1'b0;
        end
        // A capture with overflow overrides a simultaneous clear
        if (state_reg == EXEC && ual_flags[OF_BIT]) begin
            sticky_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_reg <= 1'b0;
        end else begin
            sticky_reg <= sticky_next;
        end
    end

    assign sticky_of = sticky_reg;
`endif

    assign req_ready = (state_reg == IDLE);
    assign rsp_valid = (state_reg == RESP);
    assign ual_in0   = in0_reg;
    assign ual_in1   = in1_reg;
    assign ual_sel   = sel_reg;
    assign rsp_data  = data_reg;
    assign rsp_flags = flags_reg;
    assign rsp_err   = err_reg;

endmodule

// File: tb/tb_ual_sequencer.sv
// Self-checking bench for ual_sequencer: behavioural UAL model, response scoreboard, directed and random traffic.
module tb_ual_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid, req_ready;
    logic [2:0] req_op;
    logic [3:0] req_a, req_b;
    logic [3:0] ual_in0, ual_in1;
    logic [4:0] ual_sel;
    logic [7:0] ual_out;
    logic [1:0] ual_flags;
    logic       rsp_valid, rsp_ready;
    logic [7:0] rsp_data;
    logic [1:0] rsp_flags;
    logic       rsp_err;
`ifdef UAL_STICKY_OF_EN
    logic       sticky_clr;
    logic       sticky_of;
`endif

    int err_cnt = 0;
    int chk_cnt = 0;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] flags;
        logic       err;
        logic [4:0] sel;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    ual_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .ual_in0   (ual_in0),
        .ual_in1   (ual_in1),
        .ual_sel   (ual_sel),
        .ual_out   (ual_out),
        .ual_flags (ual_flags),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_flags (rsp_flags),
        .rsp_err   (rsp_err)
`ifdef UAL_STICKY_OF_EN
        ,
        .sticky_clr(sticky_clr),
        .sticky_of (sticky_of)
`endif
    );

    // Behavioural UAL: returns {OF, ZF, out[7:0]}
    function automatic logic [9:0] ual_model(input logic [4:0] sel, input logic [3:0] a, input logic [3:0] b);
        logic [7:0] r;
        logic [3:0] s;
        logic       of;
        r  = 8'd0;
        s  = 4'd0;
        of = 1'b0;
        case (sel)
            5'b00001: r = {4'h0, ~(a & b)};
            5'b00010: r = {4'h0, a ^ b};
            5'b00100: begin
                r  = 8'(a) + 8'(b);
                s  = a + b;
                of = (a[3] == b[3]) && (s[3] != a[3]);
            end
            5'b01000: begin
                s  = a - b;
                r  = {4'h0, s};
                of = (a[3] != b[3]) && (s[3] != a[3]);
            end
            5'b10000: r = 8'(a) * 8'(b);
            default:  r = 8'd0;
        endcase
        return {of, (r == 8'h00), r};
    endfunction

    function automatic logic [4:0] op_to_sel(input logic [2:0] op);
        case (op)
            3'd0:    return 5'd1;
            3'd1:    return 5'd2;
            3'd2:    return 5'd4;
            3'd3:    return 5'd8;
            3'd4:    return 5'd16;
            default: return 5'd0;
        endcase
    endfunction

    always_comb {ual_flags, ual_out} = ual_model(ual_sel, ual_in0, ual_in1);

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: push on request handshake, pop and compare on response handshake
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            sb_q.delete();
        end else begin
            if (rsp_valid && rsp_ready) begin
                if (sb_q.size() == 0) begin
                    check_eq("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    $display("rsp data=0x%02h flags=%b err=%b sel=%b (exp data=0x%02h flags=%b err=%b sel=%b)",
                             rsp_data, rsp_flags, rsp_err, ual_sel, e.data, e.flags, e.err, e.sel);
                    check_eq("rsp_data", 32'(rsp_data), 32'(e.data));
                    check_eq("rsp_flags", 32'(rsp_flags), 32'(e.flags));
                    check_eq("rsp_err", 32'(rsp_err), 32'(e.err));
                    check_eq("rsp_sel", 32'(ual_sel), 32'(e.sel));
                end
            end
            if (req_valid && req_ready) begin
                if (req_op <= 3'd4) begin
                    e.sel = op_to_sel(req_op);
                    {e.flags, e.data} = ual_model(e.sel, req_a, req_b);
                    e.err = 1'b0;
                end else begin
                    e = '0;
                    e.err = 1'b1;
                end
                sb_q.push_back(e);
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Returns just after the accepting edge
    task automatic send(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (req_ready) break;
            step();
        end
        if (!req_ready) check_eq("req_ready_timeout", 32'd0, 32'd1);
        step();
        req_valid = 1'b0;
    endtask

    task automatic drain(input bit rnd);
        for (int i = 0; i < 100 && sb_q.size() != 0; i++) begin
            rsp_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            step();
        end
        check_eq("drain_empty", 32'(sb_q.size()), 32'd0);
        rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = 3'd0;
        req_a     = 4'd0;
        req_b     = 4'd0;
        rsp_ready = 1'b0;
`ifdef UAL_STICKY_OF_EN
        sticky_clr = 1'b0;
`endif
        step(2);
        check_eq("rst_req_ready", 32'(req_ready), 32'd1);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_ual_sel", 32'(ual_sel), 32'd0);
        check_eq("rst_ual_in0", 32'(ual_in0), 32'd0);
        check_eq("rst_rsp_data", 32'(rsp_data), 32'd0);
        check_eq("rst_rsp_err", 32'(rsp_err), 32'd0);
`ifdef UAL_STICKY_OF_EN
        check_eq("rst_sticky", 32'(sticky_of), 32'd0);
`endif
        rst_n = 1'b1;
        step();

        // ADD 7+1: sel during EXEC, response one edge later
        send(3'd2, 4'd7, 4'd1);
        check_eq("add_sel", 32'(ual_sel), 32'd4);
        check_eq("add_in0", 32'(ual_in0), 32'd7);
        check_eq("add_in1", 32'(ual_in1), 32'd1);
        check_eq("add_exec_valid", 32'(rsp_valid), 32'd0);
        check_eq("add_exec_ready", 32'(req_ready), 32'd0);
        step();
        check_eq("add_rsp_valid", 32'(rsp_valid), 32'd1);
        drain(1'b0);
        check_eq("add_idle_ready", 32'(req_ready), 32'd1);
        check_eq("idle_clear_sel", 32'(ual_sel), 32'd0);
        check_eq("idle_clear_in0", 32'(ual_in0), 32'd0);
        check_eq("idle_clear_in1", 32'(ual_in1), 32'd0);

        // SUB 3-3 with rsp_ready held high
        rsp_ready = 1'b1;
        send(3'd3, 4'd3, 4'd3);
        check_eq("sub_sel", 32'(ual_sel), 32'd8);
        step();
        check_eq("sub_rsp_valid", 32'(rsp_valid), 32'd1);
        step();
        check_eq("sub_ready_after", 32'(req_ready), 32'd1);
        check_eq("sub_valid_after", 32'(rsp_valid), 32'd0);
        rsp_ready = 1'b0;

        // MUL 15*15 under 5 cycles of backpressure with a competing request
        send(3'd4, 4'hF, 4'hF);
        step();
        req_op    = 3'd0;
        req_a     = 4'd1;
        req_b     = 4'd2;
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check_eq("mul_hold_data", 32'(rsp_data), 32'hE1);
            check_eq("mul_hold_ready", 32'(req_ready), 32'd0);
            check_eq("mul_hold_valid", 32'(rsp_valid), 32'd1);
            check_eq("mul_hold_in0", 32'(ual_in0), 32'hF);
            step();
        end
        req_valid = 1'b0;
        drain(1'b0);
        check_eq("mul_idle_ready", 32'(req_ready), 32'd1);

        // Reset in the middle of an XOR
        send(3'd1, 4'd5, 4'd3);
        check_eq("xor_sel", 32'(ual_sel), 32'd2);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_in0", 32'(ual_in0), 32'd0);
        check_eq("midrst_in1", 32'(ual_in1), 32'd0);
        check_eq("midrst_sel", 32'(ual_sel), 32'd0);
        check_eq("midrst_data", 32'(rsp_data), 32'd0);
        check_eq("midrst_flags", 32'(rsp_flags), 32'd0);
        check_eq("midrst_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_eq("postrst_valid", 32'(rsp_valid), 32'd0);
            check_eq("postrst_ready", 32'(req_ready), 32'd1);
            step();
        end
        rsp_ready = 1'b0;

        // Illegal opcode answers after one edge, then NAND 0xF,0xF
        send(3'd6, 4'd9, 4'd9);
        check_eq("ill_rsp_valid", 32'(rsp_valid), 32'd1);
        check_eq("ill_rsp_err", 32'(rsp_err), 32'd1);
        check_eq("ill_rsp_data", 32'(rsp_data), 32'd0);
        check_eq("ill_sel", 32'(ual_sel), 32'd0);
        drain(1'b0);
        send(3'd0, 4'hF, 4'hF);
        drain(1'b0);

`ifdef UAL_STICKY_OF_EN
        send(3'd2, 4'd7, 4'd1);
        step();
        check_eq("sticky_set", 32'(sticky_of), 32'd1);
        drain(1'b0);
        send(3'd2, 4'd1, 4'd1);
        drain(1'b0);
        check_eq("sticky_hold", 32'(sticky_of), 32'd1);
        send(3'd2, 4'd7, 4'd1);
        sticky_clr = 1'b1;
        step();
        sticky_clr = 1'b0;
        check_eq("sticky_set_wins", 32'(sticky_of), 32'd1);
        drain(1'b0);
        sticky_clr = 1'b1;
        step();
        sticky_clr = 1'b0;
        check_eq("sticky_clear", 32'(sticky_of), 32'd0);
`endif

        // Random traffic with random response backpressure
        for (int i = 0; i < 12; i++) begin
            send(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            drain(1'b1);
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
